lsu_queued: RTL and testbench

//  Load/store execution unit for the RV32 core, successor to the single-shot memory ALU slot: accepts LB/LH/LW/LBU/LHU/SB/SH/SW from the issuer,

---
 rtl/lsu_queued_pkg.sv | 57 +++++
 rtl/lsu_queued_align.sv | 46 ++++
 rtl/lsu_queued.sv | 148 ++++++++++++++
 tb/tb_lsu_queued.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_queued_pkg.sv
// Shared core configuration for the queued load/store unit: command encoding,
// access sizes, queue entry layout and decode helpers (package core_config_pkg).
package core_config_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned LSU_DEPTH  = 4;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU,
    LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } alu_commands_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

  typedef enum logic [1:0] {E_FREE, E_SEND, E_WAIT, E_DONE} entry_state_t;

  // data holds store data until the response, then the extended load result
  typedef struct packed {
    entry_state_t            state;
    logic                    is_load;
    logic                    is_signed;
    mem_size_t               size;
    logic                    err;
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN-1:0]         addr;
    logic [XLEN-1:0]         data;
  } lsu_entry_t;

  function automatic logic is_lsu(alu_commands_t c);
    return c inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic logic cmd_is_load(alu_commands_t c);
    return c inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

  function automatic logic cmd_is_signed(alu_commands_t c);
    return c inside {LSU_LB, LSU_LH};
  endfunction

  function automatic mem_size_t cmd_size(alu_commands_t c);
    mem_size_t s;
    case (c)
      LSU_LB, LSU_LBU, LSU_SB: s = BYTE;
      LSU_LH, LSU_LHU, LSU_SH: s = HALF;
      default:                 s = WORD;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(mem_size_t s, logic [1:0] off);
    return ((s == HALF) && off[0]) || ((s == WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_queued_align.sv
// Byte-lane helper for the LSU: store byte enables and lane replication,
// load word extraction with sign/zero extension.
module lsu_align
  import core_config_pkg::*;
(
  input  mem_size_t        st_size,
  input  logic [1:0]       st_off,
  input  logic [XLEN-1:0]  st_data,
  output logic [3:0]       st_be,
  output logic [XLEN-1:0]  st_lanes,
  input  mem_size_t        ld_size,
  input  logic             ld_signed,
  input  logic [1:0]       ld_off,
  input  logic [XLEN-1:0]  ld_word,
  output logic [XLEN-1:0]  ld_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    st_be    = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      HALF: begin
        st_be    = 4'b0011 << {st_off[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = ld_word >> {ld_off, 3'b000};
    ld_data = shifted;
    case (ld_size)
      BYTE:    ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      HALF:    ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_queued.sv
// Queued load/store unit: DEPTH in-flight accesses on a req/gnt/rvalid bus with
// in-order commit. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module lsu_queued #(
  parameter int unsigned XLEN       = core_config_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W,
  parameter int unsigned DEPTH      = core_config_pkg::LSU_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  logic [XLEN-1:0]                arg0,
  input  logic [XLEN-1:0]                arg1,
  input  logic [XLEN-1:0]                imm,
  input  core_config_pkg::alu_commands_t cmd,
  input  logic [REG_ADDR_W-1:0]          i_rd,
  output logic                           busy,
  output logic                           i_error,
  output logic [XLEN-1:0]                res,
  output logic [REG_ADDR_W-1:0]          o_rd,
  output logic                           valid,
  output logic                           o_error,
  output logic                           req,
  input  logic                           clear,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [XLEN-1:0]                mem_addr,
  output logic [XLEN-1:0]                mem_wdata,
  output logic [XLEN/8-1:0]              mem_be,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  input  logic [XLEN-1:0]                mem_rdata,
  input  logic                           mem_err
);
  import core_config_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);

  lsu_entry_t      q [DEPTH];
  logic [PW-1:0]   tail, head, send_ptr, resp_ptr, head_nx;
  logic [PW:0]     count;

  logic            lsu_op, accept, pop, gnt_fire, send_skip, rsp_fire, nx_done;
  logic [XLEN-1:0] eff_addr, ent_addr, ent_data, st_lanes, ld_data;
  logic [3:0]      st_be;
  logic            ent_err;
  mem_size_t       isz;

  assign lsu_op   = is_lsu(cmd);
  assign busy     = (count == (PW+1)'(DEPTH));
  assign accept   = i_valid && lsu_op && !busy;
  assign pop      = clear && valid;
  assign eff_addr = arg0 + imm;
  assign isz      = cmd_size(cmd);
  assign ent_data = cmd_is_load(cmd) ? '0 : arg1;

  always_comb begin
    ent_addr = eff_addr;
    ent_err  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    ent_err  = misaligned(isz, eff_addr[1:0]);
`else
    case (isz)
      HALF:    ent_addr[0]   = 1'b0;
      WORD:    ent_addr[1:0] = 2'b00;
      default: ;
    endcase
`endif
  end

  assign mem_req   = (q[send_ptr].state == E_SEND) && !q[send_ptr].err;
  assign mem_we    = mem_req && !q[send_ptr].is_load;
  assign mem_addr  = mem_req ? {q[send_ptr].addr[XLEN-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? st_be : '0;
  assign mem_wdata = mem_we ? st_lanes : '0;
  assign gnt_fire  = mem_req && mem_gnt;
  // A faulted entry waits until every earlier access has responded so the
  // response pointer can step over it without reordering.
  assign send_skip = (q[send_ptr].state == E_SEND) && q[send_ptr].err && (resp_ptr == send_ptr);
  assign rsp_fire  = mem_rvalid && (q[resp_ptr].state == E_WAIT);

  assign head_nx   = pop ? head + 1'b1 : head;
  assign nx_done   = (q[head_nx].state == E_DONE);

  lsu_align u_align (
    .st_size   (q[send_ptr].size),
    .st_off    (q[send_ptr].addr[1:0]),
    .st_data   (q[send_ptr].data),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_size   (q[resp_ptr].size),
    .ld_signed (q[resp_ptr].is_signed),
    .ld_off    (q[resp_ptr].addr[1:0]),
    .ld_word   (mem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '{default: '0};
      tail     <= '0;
      head     <= '0;
      send_ptr <= '0;
      resp_ptr <= '0;
      count    <= '0;
      valid    <= 1'b0;
      res      <= '0;
      o_rd     <= '0;
      o_error  <= 1'b0;
      req      <= 1'b0;
      i_error  <= 1'b0;
    end else begin
      if (accept) begin
        q[tail] <= '{state: E_SEND, is_load: cmd_is_load(cmd), is_signed: cmd_is_signed(cmd),
                     size: isz, err: ent_err, rd: i_rd, addr: ent_addr, data: ent_data};
        tail <= tail + 1'b1;
      end
      if (gnt_fire) begin
        q[send_ptr].state <= E_WAIT;
        send_ptr          <= send_ptr + 1'b1;
      end
      if (send_skip) begin
        q[send_ptr].state <= E_DONE;
        q[send_ptr].data  <= '0;
        send_ptr          <= send_ptr + 1'b1;
        resp_ptr          <= resp_ptr + 1'b1;
      end
      if (rsp_fire) begin
        q[resp_ptr].state <= E_DONE;
        q[resp_ptr].err   <= mem_err;
        q[resp_ptr].data  <= q[resp_ptr].is_load ? ld_data : '0;
        resp_ptr          <= resp_ptr + 1'b1;
      end
      if (pop) begin
        q[head].state <= E_FREE;
        head          <= head + 1'b1;
      end
      count   <= count + (PW+1)'(accept) - (PW+1)'(pop);
      // Commit view looks past the entry being popped so back-to-back pops see no bubble
      valid   <= nx_done;
      res     <= nx_done ? q[head_nx].data : '0;
      o_rd    <= nx_done ? q[head_nx].rd : '0;
      o_error <= nx_done && q[head_nx].err;
      req     <= nx_done && q[head_nx].is_load && (q[head_nx].rd != '0);
      i_error <= i_valid && !lsu_op;
    end
  end

endmodule

// File: tb/tb_lsu_queued.sv
// Directed self-checking bench for lsu_queued with a small in-order bus responder;
// expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_queued;
  import core_config_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n, i_valid, clear;
  logic [31:0]   arg0, arg1, imm;
  alu_commands_t cmd;
  logic [4:0]    i_rd;
  logic          busy, i_error, valid, o_error, req;
  logic [31:0]   res;
  logic [4:0]    o_rd;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          gnt_en = 1'b1;
  int          lat = 2;
  int          due_q[$];
  logic [31:0] dat_q[$];
  bit          err_q[$];
  logic [31:0] rdq[$];
  bit          errq[$];
  bit          req_seen = 1'b0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  lsu_queued #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .arg0(arg0), .arg1(arg1), .imm(imm),
    .cmd(cmd), .i_rd(i_rd), .busy(busy), .i_error(i_error), .res(res), .o_rd(o_rd),
    .valid(valid), .o_error(o_error), .req(req), .clear(clear),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: grants at the negedge, answers in order lat cycles after grant
  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0; mem_err = 0; mem_rdata = '0; mem_gnt = 0;
      if (!rst_n) begin
        due_q.delete(); dat_q.delete(); err_q.delete();
      end else begin
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          mem_rvalid = 1;
          mem_rdata  = dat_q.pop_front();
          mem_err    = err_q.pop_front();
          void'(due_q.pop_front());
        end
        if (mem_req) begin
          req_seen = 1;
          if (gnt_en) begin
            mem_gnt = 1;
            seen_addr = mem_addr; seen_be = mem_be; seen_we = mem_we; seen_wdata = mem_wdata;
            due_q.push_back(cyc + lat);
            if (!mem_we && rdq.size() > 0) dat_q.push_back(rdq.pop_front());
            else dat_q.push_back(32'h0);
            if (!mem_we && errq.size() > 0) err_q.push_back(errq.pop_front());
            else err_q.push_back(1'b0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(input alu_commands_t c, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] im, input logic [4:0] rd);
    @(negedge clk);
    i_valid = 1; cmd = c; arg0 = a0; arg1 = a1; imm = im; i_rd = rd;
    @(negedge clk);
    i_valid = 0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; i_valid = 0; clear = 0; cmd = ALU_ADD;
    arg0 = '0; arg1 = '0; imm = '0; i_rd = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, i_error, valid, o_error, req, mem_req, mem_we} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000000", {busy, i_error, valid, o_error, req, mem_req, mem_we}); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h exp 0", res); end
    checks++; if (o_rd !== 5'h0) begin errors++; $display("FAIL reset_o_rd got %h exp 0", o_rd); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      errors++; $display("FAIL reset_bus got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_be); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_i_error();
    issue(ALU_ADD, 32'h100, 32'h0, 32'h0, 5'd3);
    checks++; if (i_error !== 1'b1) begin errors++; $display("FAIL ierr_pulse got %b exp 1", i_error); end
    @(negedge clk);
    checks++; if (i_error !== 1'b0) begin errors++; $display("FAIL ierr_clear got %b exp 0", i_error); end
    checks++; if ({mem_req, valid, busy} !== 3'b0) begin
      errors++; $display("FAIL ierr_noqueue got %b exp 000", {mem_req, valid, busy}); end
  endtask

  task automatic test_lw();
    bit ok;
    rdq.delete(); errq.delete(); lat = 2; gnt_en = 1;
    rdq.push_back(32'hDEADBEEF);
    issue(LSU_LW, 32'h100, 32'h0, 32'h0, 5'd5);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_we !== 1'b0) begin
      errors++; $display("FAIL lw_bus got req=%b addr=%h be=%b we=%b exp 1/100/1111/0", mem_req, mem_addr, mem_be, mem_we); end
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lw_timeout got valid=0 exp valid=1"); end
    checks++; if (res !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_res got %h exp deadbeef", res); end
    checks++; if (o_rd !== 5'd5 || req !== 1'b1 || o_error !== 1'b0) begin
      errors++; $display("FAIL lw_head got rd=%0d req=%b err=%b exp 5/1/0", o_rd, req, o_error); end
    do_clear();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lw_clear got %b exp 0", valid); end
  endtask

  task automatic test_byte_loads();
    bit ok;
    rdq.delete(); rdq.push_back(32'h80FF_0000); rdq.push_back(32'h80FF_0000);
    issue(LSU_LB, 32'h100, 32'h0, 32'h3, 5'd6);
    wait_valid(20, ok);
    checks++; if (!ok || seen_be !== 4'b1000 || seen_addr !== 32'h100) begin
      errors++; $display("FAIL lb_bus got ok=%b be=%b addr=%h exp 1/1000/100", ok, seen_be, seen_addr); end
    checks++; if (res !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_res got %h exp ffffff80", res); end
    do_clear();
    issue(LSU_LBU, 32'h100, 32'h0, 32'h3, 5'd6);
    wait_valid(20, ok);
    checks++; if (!ok || res !== 32'h00000080) begin errors++; $display("FAIL lbu_res got %h exp 00000080", res); end
    checks++; if (req !== 1'b1 || o_rd !== 5'd6) begin errors++; $display("FAIL lbu_head got req=%b rd=%0d exp 1/6", req, o_rd); end
    do_clear();
  endtask

  task automatic test_sh();
    bit ok;
    rdq.delete();
    issue(LSU_SH, 32'h100, 32'h1234ABCD, 32'h2, 5'd7);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL sh_req got req=%b we=%b exp 1/1", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1100) begin
      errors++; $display("FAIL sh_addr_be got %h/%b exp 100/1100", mem_addr, mem_be); end
    checks++; if (mem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", mem_wdata); end
    wait_valid(20, ok);
    checks++; if (!ok || req !== 1'b0 || res !== 32'h0 || o_error !== 1'b0) begin
      errors++; $display("FAIL sh_commit got ok=%b req=%b res=%h err=%b exp 1/0/0/0", ok, req, res, o_error); end
    do_clear();
  endtask

  task automatic test_full();
    bit ok;
    rdq.delete(); gnt_en = 0; lat = 1;
    for (int k = 0; k < 3; k++) issue(LSU_LW, 32'h200 + 32'(4 * k), 32'h0, 32'h0, 5'(k + 1));
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_three got busy=%b exp 0", busy); end
    issue(LSU_LW, 32'h20C, 32'h0, 32'h0, 5'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy); end
    issue(LSU_LW, 32'h210, 32'h0, 32'h0, 5'd9);
    checks++; if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL full_hold got busy=%b req=%b addr=%h exp 1/1/200", busy, mem_req, mem_addr); end
    for (int k = 0; k < 4; k++) rdq.push_back(32'hA0 + 32'(k));
    gnt_en = 1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(40, ok);
      checks++; if (!ok || o_rd !== 5'(k + 1) || res !== 32'hA0 + 32'(k)) begin
        errors++; $display("FAIL full_order%0d got ok=%b rd=%0d res=%h exp 1/%0d/%h", k, ok, o_rd, res, k + 1, 32'hA0 + k); end
      do_clear();
    end
    repeat (10) @(negedge clk);
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_refused got valid=%b busy=%b exp 0/0", valid, busy); end
  endtask

  task automatic test_bus_error();
    bit ok;
    rdq.delete(); errq.delete(); lat = 2;
    for (int k = 0; k < 3; k++) begin
      rdq.push_back(32'h11 * 32'(k + 1));
      errq.push_back(k == 1);
    end
    for (int k = 0; k < 3; k++) issue(LSU_LW, 32'h300 + 32'(4 * k), 32'h0, 32'h0, 5'(k + 10));
    for (int k = 0; k < 3; k++) begin
      wait_valid(40, ok);
      checks++; if (!ok || o_rd !== 5'(k + 10) || o_error !== (k == 1)) begin
        errors++; $display("FAIL err_entry%0d got ok=%b rd=%0d err=%b exp 1/%0d/%0d", k, ok, o_rd, o_error, k + 10, k == 1); end
      do_clear();
    end
  endtask

  task automatic test_misalign();
    bit ok;
    rdq.delete(); errq.delete(); req_seen = 0; seen_addr = '0;
    rdq.push_back(32'hCAFEF00D);
    issue(LSU_LW, 32'h100, 32'h0, 32'h1, 5'd9);
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mis_timeout got valid=0 exp valid=1"); end
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL mis_noreq got req_seen=%b exp 0", req_seen); end
    checks++; if (o_error !== 1'b1 || res !== 32'h0) begin
      errors++; $display("FAIL mis_fault got err=%b res=%h exp 1/0", o_error, res); end
`else
    checks++; if (seen_addr !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 100", seen_addr); end
    checks++; if (o_error !== 1'b0 || res !== 32'hCAFEF00D) begin
      errors++; $display("FAIL mis_access got err=%b res=%h exp 0/cafef00d", o_error, res); end
`endif
    do_clear();
  endtask

  task automatic test_reset_mid();
    rdq.delete(); errq.delete(); lat = 20;
    for (int k = 0; k < 3; k++) issue(LSU_LW, 32'h400 + 32'(4 * k), 32'h0, 32'h0, 5'(k + 1));
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if ({busy, valid, o_error, req, mem_req, mem_we, i_error} !== 7'b0) begin
      errors++; $display("FAIL rstmid_flags got %b exp 0000000", {busy, valid, o_error, req, mem_req, mem_we, i_error}); end
    checks++; if ({res, o_rd, mem_addr, mem_wdata, mem_be} !== 105'h0) begin
      errors++; $display("FAIL rstmid_data got res=%h rd=%h addr=%h be=%b exp 0", res, o_rd, mem_addr, mem_be); end
    repeat (2) @(negedge clk);
    rst_n = 1; lat = 2;
    repeat (25) @(negedge clk);
    checks++; if (valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got valid=%b req=%b exp 0/0", valid, mem_req); end
  endtask

  initial begin
    test_reset();
    test_i_error();
    test_lw();
    test_byte_loads();
    test_sh();
    test_full();
    test_bus_error();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
